// File: rtl/pool_pkg.sv
// Shared definitions for the max-pooling datapath: word/window geometry,
// feeder state encoding and slot packing helpers.
package pool_pkg;

  localparam int DATA_W = 22;
  localparam int WIN    = 16;
  localparam int SLOT_W = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_BUSY = 1'b1
  } pool_state_t;

  // Slot k occupies bits [k*DATA_W +: DATA_W]; slot 0 feeds input1.
  function automatic logic [DATA_W-1:0] get_slot(input logic [WIN*DATA_W-1:0] win,
                                                 input int unsigned k);
    return win[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [WIN*DATA_W-1:0] put_slot(input logic [WIN*DATA_W-1:0] win,
                                                     input int unsigned k,
                                                     input logic [DATA_W-1:0] word);
    logic [WIN*DATA_W-1:0] packed_win;
    packed_win = win;
    packed_win[k*DATA_W +: DATA_W] = word;
    return packed_win;
  endfunction

endpackage

// File: rtl/pool_window_feeder_if.sv
// Bundle of the feeder's pixel stream, pooling-unit and result signals.
// master is the feeder side, slave is the upstream/pooling-unit side.
interface pool_window_feeder_if;
  import pool_pkg::*;

  logic [DATA_W-1:0]     pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [WIN*DATA_W-1:0] win_data;
  logic                  enable;
  logic                  pool_done;
  logic [DATA_W-1:0]     pool_result;
  logic [DATA_W-1:0]     res_out;
  logic                  res_valid;
  logic                  frame_done;
  logic                  err_timeout;

  modport master (
    input  pix_in, pix_valid, pool_done, pool_result,
    output pix_ready, win_data, enable, res_out, res_valid, frame_done, err_timeout
  );

  modport slave (
    output pix_in, pix_valid, pool_done, pool_result,
    input  pix_ready, win_data, enable, res_out, res_valid, frame_done, err_timeout
  );

endinterface

// File: rtl/pool_window_reg.sv
// WIN x DATA_W window storage with indexed slot write; presented flat so it
// can drive the pooling unit's input1..inputN directly.
module pool_window_reg
  import pool_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [SLOT_W-1:0]     wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [WIN*DATA_W-1:0] win_data
);

  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (wr_en && (wr_idx == SLOT_W'(gi))) begin
          slot_reg <= wr_data;
        end
      end

      assign win_data[gi*DATA_W +: DATA_W] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/pool_window_feeder.sv
// Packs a serial word stream into pooling windows, holds enable until the
// pooling unit finishes, and forwards the result with frame tracking.
module pool_window_feeder
  import pool_pkg::*;
#(
  parameter int FRAME_WORDS = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pool_window_feeder_if.master bus
);

  localparam int WIN_PER_FRAME = FRAME_WORDS / WIN;
  localparam int WCNT_W        = (WIN_PER_FRAME > 1) ? $clog2(WIN_PER_FRAME) : 1;
  localparam int BUSY_W        = $clog2(TIMEOUT + 1);

  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(WIN - 1);
  localparam logic [WCNT_W-1:0] LAST_WIN    = WCNT_W'(WIN_PER_FRAME - 1);
  localparam logic [BUSY_W-1:0] TIMEOUT_CNT = BUSY_W'(TIMEOUT);

  pool_state_t       state_reg;
  logic              pix_ready_reg;
  logic              enable_reg;
  logic [SLOT_W-1:0] slot_idx_reg;
  logic [WCNT_W-1:0] win_cnt_reg;
  logic [BUSY_W-1:0] busy_cnt_reg;
  logic [DATA_W-1:0] res_out_reg;
  logic              res_valid_reg;
  logic              frame_done_reg;
  logic              err_timeout_reg;

  logic              accept;
  logic [BUSY_W-1:0] busy_inc;

  assign accept   = (state_reg == ST_FILL) && bus.pix_valid;
  assign busy_inc = busy_cnt_reg + 1'b1;

  pool_window_reg u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_idx   (slot_idx_reg),
    .wr_data  (bus.pix_in),
    .win_data (bus.win_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_FILL;
      pix_ready_reg   <= 1'b1;
      enable_reg      <= 1'b0;
      slot_idx_reg    <= '0;
      win_cnt_reg     <= '0;
      busy_cnt_reg    <= '0;
      res_out_reg     <= '0;
      res_valid_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      res_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            if (slot_idx_reg == LAST_SLOT) begin
              slot_idx_reg  <= '0;
              busy_cnt_reg  <= '0;
              state_reg     <= ST_BUSY;
              pix_ready_reg <= 1'b0;
              enable_reg    <= 1'b1;
            end else begin
              slot_idx_reg <= slot_idx_reg + 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // A done on the same edge as the timeout still delivers the result.
          if (bus.pool_done) begin
            res_out_reg   <= bus.pool_result;
            res_valid_reg <= 1'b1;
            if (win_cnt_reg == LAST_WIN) begin
              win_cnt_reg    <= '0;
              frame_done_reg <= 1'b1;
            end else begin
              win_cnt_reg <= win_cnt_reg + 1'b1;
            end
            state_reg     <= ST_FILL;
            pix_ready_reg <= 1'b1;
            enable_reg    <= 1'b0;
          end else if (busy_inc == TIMEOUT_CNT) begin
            err_timeout_reg <= 1'b1;
            state_reg       <= ST_FILL;
            pix_ready_reg   <= 1'b1;
            enable_reg      <= 1'b0;
          end else begin
            busy_cnt_reg <= busy_inc;
          end
        end
        default: begin
          state_reg     <= ST_FILL;
          pix_ready_reg <= 1'b1;
          enable_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready   = pix_ready_reg;
  assign bus.enable      = enable_reg;
  assign bus.res_out     = res_out_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench for pool_window_feeder with a behavioural pooling unit
// whose done latency can be fixed, held high, or suppressed.
module tb_pool_window_feeder;
  import pool_pkg::*;

  localparam int WW = WIN * DATA_W;

  typedef logic [DATA_W-1:0] win_t [WIN];
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              last;
  } exp_res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_window_feeder_if bus();

  pool_window_feeder #(.FRAME_WORDS(64), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Scoreboard and model state
  exp_res_t          exp_res_q[$];
  logic [WW-1:0]     exp_win_q[$];
  logic [DATA_W-1:0] model_res_q[$];
  logic [DATA_W-1:0] res_log[$];
  int  done_lat   = 3;
  bit  done_hold  = 1'b0;
  bit  done_never = 1'b0;
  int  tb_win_cnt = 0;
  int  res_count = 0, frame_count = 0;
  int  en_len = 0, last_en_len = 0;
  int  cycle = 0, last_res_cycle = 0, res_period = 0;
  win_t cur;

  // Pooling-unit model: loads the window's maximum on the first BUSY cycle.
  int en_cycles = 0;
  initial begin
    bus.pool_done   = 1'b0;
    bus.pool_result = '0;
  end
  always @(negedge clk) begin
    if (bus.enable) begin
      if (en_cycles == 0 && model_res_q.size() > 0) bus.pool_result = model_res_q.pop_front();
      en_cycles++;
    end else begin
      en_cycles = 0;
    end
    bus.pool_done = done_hold || (!done_never && bus.enable && (en_cycles >= done_lat));
  end

  // Output monitor
  logic     en_prev = 1'b0;
  exp_res_t er_mon;
  always @(negedge clk) begin
    cycle++;
    if (rst_n) begin
      if (bus.enable && !en_prev) begin
        check_eq("ready_low_in_busy", WW'(bus.pix_ready), WW'(0));
        if (exp_win_q.size() > 0) check_eq("window", bus.win_data, exp_win_q.pop_front());
        else check_eq("window_unexpected", WW'(bus.enable), WW'(0));
        en_len = 0;
      end
      if (bus.enable) en_len++;
      if (!bus.enable && en_prev) begin
        last_en_len = en_len;
        check_eq("ready_after_busy", WW'(bus.pix_ready), WW'(1));
      end
      if (bus.res_valid) begin
        res_count++;
        res_log.push_back(bus.res_out);
        if (bus.frame_done) frame_count++;
        res_period     = cycle - last_res_cycle;
        last_res_cycle = cycle;
        if (exp_res_q.size() > 0) begin
          er_mon = exp_res_q.pop_front();
          check_eq("res_out", WW'(bus.res_out), WW'(er_mon.res));
          check_eq("frame_done", WW'(bus.frame_done), WW'(er_mon.last));
        end else begin
          check_eq("unexpected_res", WW'(bus.res_valid), WW'(0));
        end
      end else if (bus.frame_done) begin
        check_eq("frame_done_alone", WW'(bus.frame_done), WW'(0));
      end
    end
    en_prev = bus.enable;
  end

  task automatic drive_word(input logic [DATA_W-1:0] w);
    int n = 0;
    while (!bus.pix_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check_eq("ready_wait", WW'(bus.pix_ready), WW'(1));
    bus.pix_valid = 1'b1;
    bus.pix_in    = w;
    @(negedge clk);
  endtask

  task automatic send_window(input win_t words, input bit completes, input bit hold);
    logic [WW-1:0]     w;
    logic [DATA_W-1:0] mx;
    exp_res_t          er;
    w  = '0;
    mx = '0;
    for (int k = 0; k < WIN; k++) begin
      w[k*DATA_W +: DATA_W] = words[k];
      if (words[k] > mx) mx = words[k];
    end
    exp_win_q.push_back(w);
    model_res_q.push_back(mx);
    if (completes) begin
      er.res  = mx;
      er.last = (tb_win_cnt == 3);
      exp_res_q.push_back(er);
      tb_win_cnt = (tb_win_cnt + 1) % 4;
    end
    for (int k = 0; k < WIN; k++) drive_word(words[k]);
    bus.pix_valid = hold;
    bus.pix_in    = 22'h2AAAAA;
  endtask

  task automatic fill_seq(input int base);
    for (int k = 0; k < WIN; k++) cur[k] = DATA_W'(base + k);
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (res_count < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("res_count", WW'(res_count), WW'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    tb_win_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_cnt;
    int base_frames;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_pix_ready", WW'(bus.pix_ready), WW'(1));
    check_eq("rst_enable", WW'(bus.enable), WW'(0));
    check_eq("rst_win_data", bus.win_data, WW'(0));
    check_eq("rst_res_out", WW'(bus.res_out), WW'(0));
    check_eq("rst_res_valid", WW'(bus.res_valid), WW'(0));
    check_eq("rst_frame_done", WW'(bus.frame_done), WW'(0));
    check_eq("rst_err", WW'(bus.err_timeout), WW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single window, words 1..16, done three cycles into BUSY
    fill_seq(1);
    send_window(cur, 1'b1, 1'b0);
    wait_res(1);
    check_eq("slot0", WW'(get_slot(bus.win_data, 0)), WW'(1));
    check_eq("slot15", WW'(get_slot(bus.win_data, 15)), WW'(16));
    check_eq("enable_len", WW'(last_en_len), WW'(3));
    check_eq("single_res", WW'(bus.res_out), WW'(16));
    check_eq("single_ready", WW'(bus.pix_ready), WW'(1));
    repeat (5) @(negedge clk);
    check_eq("single_pulse", WW'(res_count), WW'(1));

    // Full frame with all-ones word in window 2, then a fifth window
    do_reset();
    base_cnt    = res_count;
    base_frames = frame_count;
    for (int w = 0; w < 4; w++) begin
      fill_seq(100 + 16 * w);
      if (w == 2) cur[5] = 22'h3FFFFF;
      send_window(cur, 1'b1, 1'b0);
    end
    wait_res(base_cnt + 4);
    check_eq("frame_third", WW'(res_log[base_cnt + 2]), WW'(22'h3FFFFF));
    check_eq("frame_pulses", WW'(frame_count - base_frames), WW'(1));
    fill_seq(200);
    send_window(cur, 1'b1, 1'b0);
    wait_res(base_cnt + 5);
    check_eq("frame_fifth", WW'(frame_count - base_frames), WW'(1));

    // Backpressure: valid held high through BUSY
    base_cnt = res_count;
    fill_seq(300);
    send_window(cur, 1'b1, 1'b1);
    fill_seq(320);
    send_window(cur, 1'b1, 1'b0);
    wait_res(base_cnt + 2);
    check_eq("bp_slot0", WW'(get_slot(bus.win_data, 0)), WW'(320));

    // Done held high: captured on the first BUSY edge, 17-cycle period
    done_hold = 1'b1;
    base_cnt  = res_count;
    fill_seq(400);
    send_window(cur, 1'b1, 1'b1);
    fill_seq(420);
    send_window(cur, 1'b1, 1'b0);
    wait_res(base_cnt + 2);
    done_hold = 1'b0;
    check_eq("coinc_en_len", WW'(last_en_len), WW'(1));
    check_eq("coinc_period", WW'(res_period), WW'(17));

    // Timeout: no done ever, window abandoned
    done_never = 1'b1;
    base_cnt   = res_count;
    fill_seq(500);
    send_window(cur, 1'b0, 1'b0);
    begin
      int n = 0;
      while (bus.enable && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    check_eq("to_err", WW'(bus.err_timeout), WW'(1));
    check_eq("to_busy_len", WW'(last_en_len), WW'(255));
    check_eq("to_ready", WW'(bus.pix_ready), WW'(1));
    check_eq("to_no_res", WW'(res_count), WW'(base_cnt));
    done_never = 1'b0;
    fill_seq(520);
    send_window(cur, 1'b1, 1'b0);
    wait_res(base_cnt + 1);
    check_eq("to_err_sticky", WW'(bus.err_timeout), WW'(1));

    // Reset after nine words of a window
    for (int k = 0; k < 9; k++) drive_word(DATA_W'(600 + k));
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pix_ready", WW'(bus.pix_ready), WW'(1));
    check_eq("arst_enable", WW'(bus.enable), WW'(0));
    check_eq("arst_win_data", bus.win_data, WW'(0));
    check_eq("arst_res_out", WW'(bus.res_out), WW'(0));
    check_eq("arst_err", WW'(bus.err_timeout), WW'(0));
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    tb_win_cnt = 0;
    @(negedge clk);
    base_cnt = res_count;
    fill_seq(700);
    send_window(cur, 1'b1, 1'b0);
    wait_res(base_cnt + 1);
    check_eq("arst_slot0", WW'(get_slot(bus.win_data, 0)), WW'(700));

    repeat (3) @(negedge clk);
    check_eq("queues_drained", WW'(exp_res_q.size() + exp_win_q.size()), WW'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
